cpu_control_fsm: RTL and testbench

//  Multi-cycle fetch/decode/execute controller feeding the register-file/ALU datapath.

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/ctrl_decode.sv | 29 ++
 rtl/cpu_control_fsm.sv | 110 +++++++++++
 tb/tb_cpu_control_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state enum, opcode/condition encodings, flag indices and legal-code check
package ctrl_pkg;
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;
  localparam logic [3:0] OP_R = 4'h0;
  localparam logic [3:0] OP_BR = 4'hC;
  localparam logic [3:0] C_ADD = 4'h1;
  localparam logic [3:0] C_AND = 4'h2;
  localparam logic [3:0] C_OR = 4'h3;
  localparam logic [3:0] C_XOR = 4'h4;
  localparam logic [3:0] C_ADDU = 4'h5;
  localparam logic [3:0] C_SUB = 4'h9;
  localparam logic [3:0] C_CMP = 4'hB;
  localparam logic [3:0] C_MOV = 4'hD;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_LT = 4'h4;
  localparam logic [3:0] CC_GE = 4'h5;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam int FLAG_N = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_L = 0;
  function automatic logic is_legal(input logic [3:0] c);
    return c inside {C_ADD, C_AND, C_OR, C_XOR, C_ADDU, C_SUB, C_CMP, C_MOV};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction-register decode into selects, opcode, immediate and control bits
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_a_sel,
  output logic [3:0]  o_b_sel,
  output logic [7:0]  o_op_code,
  output logic [15:0] o_immediate,
  output logic        o_use_imm,
  output logic        o_write,
  output logic        o_branch,
  output logic        o_legal
);
  logic [3:0] w_op;
  logic [3:0] w_ext;
  logic       w_rtype;
  assign w_op = i_ir[15:12];
  assign w_ext = i_ir[7:4];
  assign w_rtype = w_op == OP_R;
  assign o_branch = w_op == OP_BR;
  assign o_legal = w_rtype ? is_legal(w_ext) : (o_branch || is_legal(w_op));
  assign o_op_code = (!o_legal || o_branch) ? 8'h00 : w_rtype ? {4'h0, w_ext} : {w_op, 4'h0};
  assign o_use_imm = o_legal && !w_rtype && !o_branch;
  assign o_write = o_legal && !o_branch && ((w_rtype ? w_ext : w_op) != C_CMP);
  assign o_immediate = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_a_sel = i_ir[11:8];
  assign o_b_sel = i_ir[3:0];
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: fetch/decode/execute controller with branch resolution; CTRL_ILLEGAL_TRAP_EN halts on illegal encodings
module cpu_control_fsm
  import ctrl_pkg::*;
#(
  parameter int                     PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
)(
  input  logic                clk,
  input  logic                reset,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  input  logic [4:0]          flags,
  output logic [15:0]         reg_enable,
  output logic [3:0]          a_select,
  output logic [3:0]          b_select,
  output logic                use_imm,
  output logic [15:0]         immediate,
  output logic [7:0]          op_code,
  output logic                illegal
);
  state_t              r_state;
  state_t              w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_disp;
  logic [15:0]         r_ir;
  logic                r_n;
  logic                r_c;
  logic                r_z;
  logic                r_cap;
  logic [3:0]          w_a;
  logic [3:0]          w_b;
  logic [7:0]          w_op_code;
  logic [15:0]         w_imm;
  logic                w_use_imm;
  logic                w_write;
  logic                w_branch;
  logic                w_legal;
  logic                w_taken;
  logic                w_active;
  logic                w_trap;
  logic                w_unused;
  ctrl_decode u_decode (
    .i_ir        (r_ir),
    .o_a_sel     (w_a),
    .o_b_sel     (w_b),
    .o_op_code   (w_op_code),
    .o_immediate (w_imm),
    .o_use_imm   (w_use_imm),
    .o_write     (w_write),
    .o_branch    (w_branch),
    .o_legal     (w_legal)
  );
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign w_trap = !w_legal;
  assign illegal = r_state == HALT;
`else
  assign w_trap = 1'b0;
  assign illegal = 1'b0;
`endif
  assign w_unused = ^{flags[FLAG_F], flags[FLAG_L]};
  assign w_disp = {{(PC_WIDTH-8){w_imm[7]}}, w_imm[7:0]};
  assign w_taken = w_a == CC_EQ ? r_z :
                   w_a == CC_NE ? !r_z :
                   w_a == CC_CS ? r_c :
                   w_a == CC_CC ? !r_c :
                   w_a == CC_LT ? r_n :
                   w_a == CC_GE ? !r_n :
                   w_a == CC_UC;
  always_comb begin
    w_next = r_state;
    w_next = r_state == FETCH   ? (instr_valid ? DECODE : FETCH) :
             r_state == DECODE  ? (w_trap ? HALT : EXECUTE) :
             r_state == EXECUTE ? FETCH : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_cap <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && instr_valid) r_ir <= instr;
      if (r_state == FETCH && r_cap) begin
        r_n <= flags[FLAG_N];
        r_c <= flags[FLAG_C];
        r_z <= flags[FLAG_Z];
        r_cap <= 1'b0;
      end
      if (r_state == EXECUTE) begin
        r_pc <= r_pc + ((w_branch && w_taken) ? w_disp : PC_WIDTH'(1));
        r_cap <= !w_branch;
      end
    end
  end
  assign w_active = r_state == DECODE || r_state == EXECUTE;
  assign instr_req = r_state == FETCH;
  assign pc = r_pc;
  assign a_select = w_active ? w_a : 4'h0;
  assign b_select = w_active ? w_b : 4'h0;
  assign use_imm = w_active && w_use_imm;
  assign immediate = w_active ? w_imm : 16'h0000;
  assign op_code = w_active ? w_op_code : 8'h00;
  assign reg_enable = (r_state == EXECUTE && w_write && !reset) ? 16'h0001 << w_a : 16'h0000;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: table-driven and randomized self-checking bench for cpu_control_fsm
module tb_cpu_control_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [15:0] pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic [15:0] reg_enable;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic        use_imm;
  logic [15:0] immediate;
  logic [7:0]  op_code;
  logic        illegal;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] cur_pc;
  logic [4:0]  mcond;
  typedef struct {
    logic [7:0]  op;
    logic        ui;
    logic [15:0] imm;
    logic [15:0] wen;
    logic [15:0] npc;
  } exp_t;
  typedef struct {
    logic [15:0] ins;
    int          waits;
    logic [4:0]  fl;
    exp_t        e;
  } vec_t;
  vec_t tbl[12];
  cpu_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .flags       (flags),
    .reg_enable  (reg_enable),
    .a_select    (a_select),
    .b_select    (b_select),
    .use_imm     (use_imm),
    .immediate   (immediate),
    .op_code     (op_code),
    .illegal     (illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic legal_code(input logic [3:0] c);
    return c inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hD};
  endfunction
  function automatic exp_t model(input logic [15:0] i, input logic [15:0] p, input logic [4:0] c);
    exp_t e;
    logic isr, isb, leg, wr, tk;
    isr = i[15:12] == 4'h0;
    isb = i[15:12] == 4'hC;
    leg = isr ? legal_code(i[7:4]) : (isb || legal_code(i[15:12]));
    e.imm = {{8{i[7]}}, i[7:0]};
    e.op = (!leg || isb) ? 8'h00 : isr ? {4'h0, i[7:4]} : {i[15:12], 4'h0};
    e.ui = leg && !isr && !isb;
    wr = leg && !isb && (isr ? i[7:4] != 4'hB : i[15:12] != 4'hB);
    e.wen = wr ? (16'h0001 << i[11:8]) : 16'h0000;
    case (i[11:8])
      4'h0: tk = c[1];
      4'h1: tk = !c[1];
      4'h2: tk = c[3];
      4'h3: tk = !c[3];
      4'h4: tk = c[4];
      4'h5: tk = !c[4];
      4'hE: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    e.npc = (isb && tk) ? p + e.imm : p + 16'h0001;
    return e;
  endfunction
  task automatic run(input logic [15:0] ins, input int waits, input logic [4:0] fl, input exp_t e);
    instr_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check("wait_req", instr_req, 1);
      check("wait_pc", pc, cur_pc);
      check("wait_op", op_code, 0);
      check("wait_wen", reg_enable, 0);
      check("wait_imm", immediate, 0);
      @(posedge clk); #1;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    check("fetch_req", instr_req, 1);
    check("fetch_pc", pc, cur_pc);
    check("fetch_op", op_code, 0);
    check("fetch_asel", a_select, 0);
    check("fetch_uimm", use_imm, 0);
    check("fetch_wen", reg_enable, 0);
    @(posedge clk); #1;
    instr_valid = 1'($urandom_range(0, 1));
    instr = 16'($urandom);
    @(negedge clk);
    check("dec_req", instr_req, 0);
    check("dec_op", op_code, e.op);
    check("dec_asel", a_select, ins[11:8]);
    check("dec_bsel", b_select, ins[3:0]);
    check("dec_uimm", use_imm, e.ui);
    check("dec_imm", immediate, e.imm);
    check("dec_wen", reg_enable, 0);
    @(posedge clk); #1;
    flags = fl;
    @(negedge clk);
    check("ex_op", op_code, e.op);
    check("ex_asel", a_select, ins[11:8]);
    check("ex_bsel", b_select, ins[3:0]);
    check("ex_uimm", use_imm, e.ui);
    check("ex_imm", immediate, e.imm);
    check("ex_wen", reg_enable, e.wen);
    check("ex_illegal", illegal, 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    cur_pc = e.npc;
  endtask
  initial begin
    tbl[0]  = '{16'h53FE, 0, 5'b00000, '{8'h50, 1'b1, 16'hFFFE, 16'h0008, 16'h0001}};
    tbl[1]  = '{16'h01B2, 5, 5'b00010, '{8'h0B, 1'b0, 16'hFFB2, 16'h0000, 16'h0002}};
    tbl[2]  = '{16'hCE0E, 1, 5'b00000, '{8'h00, 1'b0, 16'h000E, 16'h0000, 16'h0010}};
    tbl[3]  = '{16'hC0FC, 0, 5'b00000, '{8'h00, 1'b0, 16'hFFFC, 16'h0000, 16'h000C}};
    tbl[4]  = '{16'h01B2, 2, 5'b00000, '{8'h0B, 1'b0, 16'hFFB2, 16'h0000, 16'h000D}};
    tbl[5]  = '{16'hCE03, 0, 5'b00000, '{8'h00, 1'b0, 16'h0003, 16'h0000, 16'h0010}};
    tbl[6]  = '{16'hC0FC, 1, 5'b00000, '{8'h00, 1'b0, 16'hFFFC, 16'h0000, 16'h0011}};
    tbl[7]  = '{16'h0215, 0, 5'b01000, '{8'h01, 1'b0, 16'h0015, 16'h0004, 16'h0012}};
    tbl[8]  = '{16'hDF7F, 3, 5'b00000, '{8'hD0, 1'b1, 16'h007F, 16'h8000, 16'h0013}};
    tbl[9]  = '{16'hCE80, 0, 5'b00000, '{8'h00, 1'b0, 16'hFF80, 16'h0000, 16'hFF93}};
    tbl[10] = '{16'hCE6C, 0, 5'b00000, '{8'h00, 1'b0, 16'h006C, 16'h0000, 16'hFFFF}};
    tbl[11] = '{16'h0215, 0, 5'b00000, '{8'h01, 1'b0, 16'h0015, 16'h0004, 16'h0000}};
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    flags = 5'b00000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", instr_req, 1);
    check("rst_pc", pc, 16'h0000);
    check("rst_wen", reg_enable, 0);
    check("rst_op", op_code, 0);
    check("rst_asel", a_select, 0);
    check("rst_illegal", illegal, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cur_pc = 16'h0000;
    for (int k = 0; k < 12; k++) run(tbl[k].ins, tbl[k].waits, tbl[k].fl, tbl[k].e);
    @(negedge clk);
    check("wrap_pc", pc, 16'h0000);
    @(posedge clk); #1;
    run(16'h0215, 0, 5'b00010, '{8'h01, 1'b0, 16'h0015, 16'h0004, 16'h0001});
    instr = 16'h0215;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_wen", reg_enable, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_pc", pc, 16'h0000);
    check("abort_req", instr_req, 1);
    check("abort_op", op_code, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rstwin_req", instr_req, 1);
    check("rstwin_op", op_code, 0);
    @(posedge clk); #1;
    cur_pc = 16'h0000;
    flags = 5'b00010;
    run(16'hC104, 0, 5'b00010, '{8'h00, 1'b0, 16'h0004, 16'h0000, 16'h0004});
    mcond = 5'b00000;
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ins;
      logic [4:0]  fl;
      exp_t        e;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hC;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (ins[15:12] == 4'h0 ? !legal_code(ins[7:4]) : !(ins[15:12] == 4'hC || legal_code(ins[15:12]))) begin
        ins[15:12] = 4'h0;
        ins[7:4] = 4'h1;
      end
`endif
      fl = 5'($urandom);
      e = model(ins, cur_pc, mcond);
      run(ins, $urandom_range(0, 3), fl, e);
      if (ins[15:12] != 4'hC) mcond = fl;
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    instr = 16'h07F1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("trap_dec_illegal", illegal, 0);
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("trap_illegal", illegal, 1);
      check("trap_req", instr_req, 0);
      check("trap_wen", reg_enable, 0);
      check("trap_pc", pc, cur_pc);
      check("trap_op", op_code, 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("trap_exit_illegal", illegal, 0);
    check("trap_exit_req", instr_req, 1);
`else
    run(16'h07F1, 1, 5'b00000, '{8'h00, 1'b0, 16'hFFF1, 16'h0000, cur_pc + 16'h0001});
    @(negedge clk);
    check("nop_pc", pc, cur_pc);
    check("nop_illegal", illegal, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
